spi_fl_rd_seq: RTL and testbench

- Flash read sequencer placed directly upstream of spi_master_fl, on its controller side.
- Accepts a burst-read request: start address plus word count.
- Issues one 32-bit fast-read transaction per word to the SPI master, using the validflag/tready handshake.
- Returns each word on a valid/ready stream. Address generation, command framing and error detection live here, so the host never touches SPI-master fields.

---
 rtl/spi_fl_pkg.sv | 43 ++++
 rtl/spi_fl_hs.sv | 62 ++++++
 rtl/spi_fl_rd_seq.sv | 210 +++++++++++++++++++++
 tb/tb_spi_fl_rd_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_fl_pkg.sv
// Shared constants for the SPI flash read sequencer: opcodes, field
// encodings, state codes and small helpers for address stepping and
// read-field selection.
package spi_fl_pkg;

  // Flash command opcodes
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
  localparam logic [7:0] CMD_ENTER_4B  = 8'hB7;

  // spi_master_fl field encodings
  localparam logic [2:0] COMMTYPE_READ     = 3'b100;
  localparam logic [2:0] COMMTYPE_CMD_ONLY = 3'b000;
  localparam logic [9:0] FRAME_SINGLE      = 10'h000;
  localparam logic [9:0] FRAME_QUAD        = 10'h260;
  localparam logic [1:0] SPIMODE_STD       = 2'b00;
  localparam logic [6:0] NDATA_WORD        = 7'd32;

  // State codes, shared by the sequencer and the handshake engine
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_OUT       = 3'd4;
  localparam logic [2:0] ST_ENTER4B   = 3'd5;

  // Step to the next word; 3-byte mode wraps inside the low 24 bits
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr,
                                                 input logic        four_byte);
    logic [23:0] low;
    low = addr[23:0] + 24'd4;
    return four_byte ? (addr + 32'd4) : {8'h00, low};
  endfunction

  function automatic logic [7:0] read_cmd(input logic quad);
    return quad ? CMD_QUAD_READ : CMD_FAST_READ;
  endfunction

  function automatic logic [9:0] read_frame(input logic quad);
    return quad ? FRAME_QUAD : FRAME_SINGLE;
  endfunction

endpackage

// File: rtl/spi_fl_hs.sv
// Handshake engine for one spi_master_fl transaction:
// ISSUE (wait for tready, pulse validflag) -> WAIT_BUSY (tready must fall
// within BUSY_TO cycles) -> WAIT_DONE (tready rises with read data).
module spi_fl_hs
  import spi_fl_pkg::*;
#(
  parameter int BUSY_TO = 16
) (
  input  logic clk,
  input  logic rst,          // asynchronous, active-low
  input  logic start,        // one-cycle request to run a transaction
  input  logic m_tready,
  output logic m_validflag,
  output logic done,         // transaction finished; m_data_out valid now
  output logic timeout       // master never went busy
);

  localparam int CNT_W = $clog2(BUSY_TO + 1);

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             validflag_reg;
  logic             busy_expired;

  assign busy_expired = (cnt_reg == CNT_W'(BUSY_TO - 1));
  assign m_validflag  = validflag_reg;
  assign done         = (state_reg == ST_WAIT_DONE) && m_tready;
  assign timeout      = (state_reg == ST_WAIT_BUSY) && m_tready && busy_expired;

  // Transaction phase sequencing and busy-timeout counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      validflag_reg <= 1'b0;
    end else begin
      validflag_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) state_reg <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (m_tready) begin
            validflag_reg <= 1'b1;
            cnt_reg       <= '0;
            state_reg     <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!m_tready)        state_reg <= ST_WAIT_DONE;
          else if (busy_expired) state_reg <= ST_IDLE;
          else                  cnt_reg   <= cnt_reg + 1'b1;
        end
        ST_WAIT_DONE: begin
          if (m_tready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_fl_rd_seq.sv
// Burst flash read sequencer in front of spi_master_fl. Splits a burst
// request into one 32-bit read transaction per word and streams the words
// out on a valid/ready port. While state_reg is ST_ISSUE or ST_ENTER4B the
// spi_fl_hs engine walks ISSUE -> WAIT_BUSY -> WAIT_DONE.
// Optional feature macro: SPI_FL_RD_SEQ_ENTER4B_EN (issue 0xB7 before the
// first 4-byte-address burst that follows 3-byte traffic or reset).
module spi_fl_rd_seq
  import spi_fl_pkg::*;
#(
  parameter int NWORDS_W     = 8,
  parameter int DUMMY_SINGLE = 8,
  parameter int DUMMY_QUAD   = 8,
  parameter int BUSY_TO      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [NWORDS_W-1:0] req_nwords,
  input  logic                req_quad,
  input  logic                req_4b,
  output logic [31:0]         rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  output logic                err,
  output logic [7:0]          m_command,
  output logic [31:0]         m_address,
  output logic [2:0]          m_commtype,
  output logic [9:0]          m_frame_struct,
  output logic [1:0]          m_spimode,
  output logic [6:0]          m_ndata_bits,
  output logic [3:0]          m_dummy_cycles,
  output logic [1:0]          m_xipbit_en,
  output logic                m_dtr_en,
  output logic                m_fourbyteaddr_on,
  output logic                m_validflag,
  input  logic                m_tready,
  input  logic [31:0]         m_data_out
);

  logic [2:0]          state_reg;
  logic [NWORDS_W-1:0] remaining_reg;
  logic [31:0]         addr_reg;
  logic [31:0]         rd_data_reg;
  logic                rd_valid_reg;
  logic                rd_last_reg;
  logic                err_reg;
  logic                hs_start_reg;
  logic                fourb_reg;
  logic [7:0]          cmd_reg;
  logic [2:0]          commtype_reg;
  logic [9:0]          frame_reg;
  logic [3:0]          dummy_reg;
  logic [6:0]          ndata_reg;
  logic                sel_quad;
  logic                hs_done;
  logic                hs_timeout;

`ifdef SPI_FL_RD_SEQ_ENTER4B_EN
  logic quad_reg;
  logic in_4b_mode_reg;   // flash already switched to 4-byte addressing
  // After ENTER4B the read fields come from the latched request
  assign sel_quad = (state_reg == ST_IDLE) ? req_quad : quad_reg;
`else
  assign sel_quad = req_quad;
`endif

  assign req_ready         = (state_reg == ST_IDLE);
  assign rd_data           = rd_data_reg;
  assign rd_valid          = rd_valid_reg;
  assign rd_last           = rd_last_reg;
  assign err               = err_reg;
  assign m_command         = cmd_reg;
  assign m_address         = addr_reg;
  assign m_commtype        = commtype_reg;
  assign m_frame_struct    = frame_reg;
  assign m_spimode         = SPIMODE_STD;
  assign m_ndata_bits      = ndata_reg;
  assign m_dummy_cycles    = dummy_reg;
  assign m_xipbit_en       = 2'b00;
  assign m_dtr_en          = 1'b0;
  assign m_fourbyteaddr_on = fourb_reg;

  spi_fl_hs #(
    .BUSY_TO (BUSY_TO)
  ) u_hs (
    .clk         (clk),
    .rst         (rst),
    .start       (hs_start_reg),
    .m_tready    (m_tready),
    .m_validflag (m_validflag),
    .done        (hs_done),
    .timeout     (hs_timeout)
  );

  // Burst control: request latch, field setup, word output and addressing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      addr_reg      <= '0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      rd_last_reg   <= 1'b0;
      err_reg       <= 1'b0;
      hs_start_reg  <= 1'b0;
      fourb_reg     <= 1'b0;
      cmd_reg       <= '0;
      commtype_reg  <= '0;
      frame_reg     <= '0;
      dummy_reg     <= '0;
      ndata_reg     <= NDATA_WORD;
`ifdef SPI_FL_RD_SEQ_ENTER4B_EN
      quad_reg       <= 1'b0;
      in_4b_mode_reg <= 1'b0;
`endif
    end else begin
      hs_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            err_reg <= 1'b0;
`ifdef SPI_FL_RD_SEQ_ENTER4B_EN
            if (!req_4b) in_4b_mode_reg <= 1'b0;
`endif
            // A zero-length burst is accepted but does nothing
            if (req_nwords != '0) begin
              remaining_reg <= req_nwords;
              addr_reg      <= req_4b ? req_addr : {8'h00, req_addr[23:0]};
              fourb_reg     <= req_4b;
              hs_start_reg  <= 1'b1;
`ifdef SPI_FL_RD_SEQ_ENTER4B_EN
              quad_reg <= req_quad;
              if (req_4b && !in_4b_mode_reg) begin
                cmd_reg      <= CMD_ENTER_4B;
                commtype_reg <= COMMTYPE_CMD_ONLY;
                frame_reg    <= FRAME_SINGLE;
                dummy_reg    <= 4'd0;
                ndata_reg    <= 7'd0;
                state_reg    <= ST_ENTER4B;
              end else begin
                cmd_reg      <= read_cmd(sel_quad);
                commtype_reg <= COMMTYPE_READ;
                frame_reg    <= read_frame(sel_quad);
                dummy_reg    <= sel_quad ? 4'(DUMMY_QUAD) : 4'(DUMMY_SINGLE);
                ndata_reg    <= NDATA_WORD;
                state_reg    <= ST_ISSUE;
              end
`else
              cmd_reg      <= read_cmd(sel_quad);
              commtype_reg <= COMMTYPE_READ;
              frame_reg    <= read_frame(sel_quad);
              dummy_reg    <= sel_quad ? 4'(DUMMY_QUAD) : 4'(DUMMY_SINGLE);
              ndata_reg    <= NDATA_WORD;
              state_reg    <= ST_ISSUE;
`endif
            end
          end
        end
`ifdef SPI_FL_RD_SEQ_ENTER4B_EN
        ST_ENTER4B: begin
          if (hs_timeout) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end else if (hs_done) begin
            in_4b_mode_reg <= 1'b1;
            cmd_reg        <= read_cmd(sel_quad);
            commtype_reg   <= COMMTYPE_READ;
            frame_reg      <= read_frame(sel_quad);
            dummy_reg      <= sel_quad ? 4'(DUMMY_QUAD) : 4'(DUMMY_SINGLE);
            ndata_reg      <= NDATA_WORD;
            hs_start_reg   <= 1'b1;
            state_reg      <= ST_ISSUE;
          end
        end
`endif
        ST_ISSUE: begin
          if (hs_timeout) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end else if (hs_done) begin
            rd_data_reg  <= m_data_out;
            rd_valid_reg <= 1'b1;
            rd_last_reg  <= (remaining_reg == NWORDS_W'(1));
            state_reg    <= ST_OUT;
          end
        end
        ST_OUT: begin
          // Next transaction only starts once this word is taken
          if (rd_ready) begin
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
            addr_reg      <= next_word_addr(addr_reg, fourb_reg);
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == NWORDS_W'(1)) begin
              state_reg <= ST_IDLE;
            end else begin
              hs_start_reg <= 1'b1;
              state_reg    <= ST_ISSUE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_fl_rd_seq.sv
// Scoreboard bench for spi_fl_rd_seq with a behavioural spi_master_fl model.
module tb_spi_fl_rd_seq;

  localparam int NW = 8;
  localparam int DS = 8;
  localparam int DQ = 6;
  localparam int BT = 16;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic [NW-1:0] req_nwords;
  logic          req_quad;
  logic          req_4b;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          err;
  logic [7:0]    m_command;
  logic [31:0]   m_address;
  logic [2:0]    m_commtype;
  logic [9:0]    m_frame_struct;
  logic [1:0]    m_spimode;
  logic [6:0]    m_ndata_bits;
  logic [3:0]    m_dummy_cycles;
  logic [1:0]    m_xipbit_en;
  logic          m_dtr_en;
  logic          m_fourbyteaddr_on;
  logic          m_validflag;
  logic          m_tready;
  logic [31:0]   m_data_out;

  spi_fl_rd_seq #(
    .NWORDS_W(NW), .DUMMY_SINGLE(DS), .DUMMY_QUAD(DQ), .BUSY_TO(BT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_nwords(req_nwords), .req_quad(req_quad), .req_4b(req_4b),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last), .err(err),
    .m_command(m_command), .m_address(m_address), .m_commtype(m_commtype),
    .m_frame_struct(m_frame_struct), .m_spimode(m_spimode),
    .m_ndata_bits(m_ndata_bits), .m_dummy_cycles(m_dummy_cycles),
    .m_xipbit_en(m_xipbit_en), .m_dtr_en(m_dtr_en),
    .m_fourbyteaddr_on(m_fourbyteaddr_on), .m_validflag(m_validflag),
    .m_tready(m_tready), .m_data_out(m_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [9:0]  frame;
    logic [2:0]  commtype;
    logic [3:0]  dummy;
    logic [6:0]  ndata;
    logic        fourb;
  } vf_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } rd_t;

  vf_t exp_vf[$];
  rd_t exp_rd[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  vf_count = 0;
  int  rd_cnt   = 0;
  logic hang;
  logic tb_mode4;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] model_data(input logic [31:0] a);
    return 32'hA0A0A0A3 + (a - 32'h100);
  endfunction

  // Master model: goes busy one cycle after validflag, returns data 4 cycles later
  int          busy_cnt;
  logic [31:0] cur_addr;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tready   <= 1'b1;
      m_data_out <= '0;
      busy_cnt   <= 0;
      cur_addr   <= '0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        m_tready   <= 1'b1;
        m_data_out <= model_data(cur_addr);
      end
    end else if (m_validflag && m_tready && !hang) begin
      m_tready <= 1'b0;
      busy_cnt <= 3;
      cur_addr <= m_address;
    end
  end

  // Monitor: pop and compare every master command and every accepted word
  vf_t mon_v;
  rd_t mon_r;
  always @(negedge clk) begin
    if (rst) begin
      if (m_validflag) begin
        vf_count++;
        if (exp_vf.size() == 0) check_eq("vf_unexpected", 1, 0);
        else begin
          mon_v = exp_vf.pop_front();
          check_eq("vf_cmd", m_command, mon_v.cmd);
          check_eq("vf_addr", m_address, mon_v.addr);
          check_eq("vf_frame", m_frame_struct, mon_v.frame);
          check_eq("vf_commtype", m_commtype, mon_v.commtype);
          check_eq("vf_dummy", m_dummy_cycles, mon_v.dummy);
          check_eq("vf_ndata", m_ndata_bits, mon_v.ndata);
          check_eq("vf_4b", m_fourbyteaddr_on, mon_v.fourb);
          check_eq("vf_static", {m_spimode, m_xipbit_en, m_dtr_en}, 0);
        end
      end
      if (rd_valid && rd_ready) begin
        rd_cnt++;
        if (exp_rd.size() == 0) check_eq("rd_unexpected", 1, 0);
        else begin
          mon_r = exp_rd.pop_front();
          check_eq("rd_data", rd_data, mon_r.data);
          check_eq("rd_last", rd_last, mon_r.last);
        end
      end
    end
  end

  // Push expectations for a burst, then present the request for one cycle
  task automatic send_req(input logic [31:0] addr, input int n, input logic quad,
                          input logic fb, input logic hang_exp);
    logic [31:0] a;
    vf_t v;
    rd_t r;
    int  k;
    a = fb ? addr : {8'h00, addr[23:0]};
`ifdef SPI_FL_RD_SEQ_ENTER4B_EN
    if (!fb) tb_mode4 = 1'b0;
    if (n != 0 && fb && !tb_mode4) begin
      v = '{cmd: 8'hB7, addr: a, frame: 10'h000, commtype: 3'b000, dummy: 4'd0,
            ndata: 7'd0, fourb: 1'b1};
      exp_vf.push_back(v);
      tb_mode4 = 1'b1;
    end
`endif
    for (int i = 0; i < n; i++) begin
      if (!(hang_exp && i > 0)) begin
        v = '{cmd: quad ? 8'h6B : 8'h0B, addr: a, frame: quad ? 10'h260 : 10'h000,
              commtype: 3'b100, dummy: quad ? 4'(DQ) : 4'(DS), ndata: 7'd32, fourb: fb};
        exp_vf.push_back(v);
      end
      if (!hang_exp) begin
        r = '{data: model_data(a), last: (i == n - 1)};
        exp_rd.push_back(r);
      end
      a = fb ? a + 32'd4 : {8'h00, a[23:0] + 24'd4};
    end
    k = 0;
    while (!req_ready && k < 3000) begin @(posedge clk); #1; k++; end
    check_eq("req_ready_wait", (k < 3000), 1);
    req_addr   = addr;
    req_nwords = NW'(n);
    req_quad   = quad;
    req_4b     = fb;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!(req_ready && exp_vf.size() == 0 && exp_rd.size() == 0) && k < 3000) begin
      @(posedge clk); #1; k++;
    end
    check_eq(tag, (k < 3000), 1);
  endtask

  task automatic wait_rd_valid(input string tag);
    int k;
    k = 0;
    while (!rd_valid && k < 500) begin @(posedge clk); #1; k++; end
    check_eq(tag, (k < 500), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, req_ready, 1);
    check_eq({tag, "_rd_valid"}, rd_valid, 0);
    check_eq({tag, "_rd_last"}, rd_last, 0);
    check_eq({tag, "_rd_data"}, rd_data, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_vf"}, m_validflag, 0);
    check_eq({tag, "_mfields"}, {m_command, m_address, m_commtype, m_frame_struct,
                                 m_dummy_cycles, m_fourbyteaddr_on}, 0);
    check_eq({tag, "_ndata"}, m_ndata_bits, 7'd32);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] held_data;
  int          vf_before;
  int          rd_before;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_nwords = '0;
    req_quad = 1'b0; req_4b = 1'b0; rd_ready = 1'b1; hang = 1'b0; tb_mode4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    $display("txn single read addr=0x000100 n=1");
    send_req(32'h0000_0100, 1, 1'b0, 1'b0, 1'b0);
    wait_idle("single_done");

    $display("txn quad burst addr=0x555554 n=4");
    send_req(32'h0055_5554, 4, 1'b1, 1'b0, 1'b0);
    wait_idle("quad_done");

    $display("txn backpressure addr=0x1000 n=3 stall 50 on word 2");
    rd_ready = 1'b0;
    send_req(32'h0000_1000, 3, 1'b0, 1'b1, 1'b0);
    wait_rd_valid("bp_w1");
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    wait_rd_valid("bp_w2");
    held_data = rd_data;
    vf_before = vf_count;
    repeat (50) @(posedge clk);
    #1;
    check_eq("bp_no_vf", vf_count, vf_before);
    check_eq("bp_valid_held", rd_valid, 1);
    check_eq("bp_data_held", rd_data, held_data);
    check_eq("bp_data_value", rd_data, model_data(32'h0000_1004));
    rd_ready = 1'b1;
    wait_idle("bp_done");

    $display("txn wrap 3-byte addr=0xFFFFFC n=2");
    send_req(32'h00FF_FFFC, 2, 1'b0, 1'b0, 1'b0);
    wait_idle("wrap3_done");

    $display("txn wrap 4-byte addr=0xFFFFFFFC n=2");
    send_req(32'hFFFF_FFFC, 2, 1'b1, 1'b1, 1'b0);
    wait_idle("wrap4_done");

    $display("txn 3-byte upper bits masked addr=0xAB000200 n=1");
    send_req(32'hAB00_0200, 1, 1'b0, 1'b0, 1'b0);
    wait_idle("mask_done");

    $display("txn timeout addr=0x2000 n=2 master stuck");
    hang = 1'b1;
    rd_before = rd_cnt;
    send_req(32'h0000_2000, 2, 1'b0, 1'b0, 1'b1);
    wait_idle("to_idle");
    check_eq("to_err", err, 1);
    check_eq("to_no_rd", rd_cnt, rd_before);
    check_eq("to_rd_valid", rd_valid, 0);
    hang = 1'b0;

    $display("txn after timeout addr=0x300 n=1 clears err");
    send_req(32'h0000_0300, 1, 1'b0, 1'b0, 1'b0);
    check_eq("err_cleared", err, 0);
    wait_idle("post_to_done");
    check_eq("err_stays_clear", err, 0);

    $display("txn reset mid-burst addr=0x4000 n=4");
    rd_ready = 1'b0;
    send_req(32'h0000_4000, 4, 1'b1, 1'b1, 1'b0);
    wait_rd_valid("rst_w1");
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    wait_rd_valid("rst_w2");
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_vf.delete();
    exp_rd.delete();
    tb_mode4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rd_ready = 1'b1;
    vf_before = vf_count;
    rd_before = rd_cnt;
    repeat (30) @(posedge clk);
    #1;
    check_eq("midrst_no_vf", vf_count, vf_before);
    check_eq("midrst_no_rd", rd_cnt, rd_before);
    check_eq("midrst_idle", req_ready, 1);

    $display("txn zero-count request addr=0x5000 n=0");
    send_req(32'h0000_5000, 0, 1'b0, 1'b0, 1'b0);
    check_eq("zero_idle", req_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    check_eq("zero_no_vf", vf_count, vf_before);
    check_eq("zero_no_rd", rd_valid, 0);

    check_eq("vf_queue_empty", exp_vf.size(), 0);
    check_eq("rd_queue_empty", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
